// File: rtl/bridge_arbiter_if.sv
// Requester-side and bridge-side signal bundle of the bridge arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface bridge_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_r_wb;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_err;
    logic                   busy;
    logic [IDW-1:0]         gnt_id;
    logic                   C_in_valid;
    logic                   C_r_wb;
    logic [ADDR_W-1:0]      C_addr;
    logic [DATA_W-1:0]      C_data_w;
    logic                   C_out_valid;
    logic [DATA_W-1:0]      C_data_r;

    modport slave (
        input  req_valid, req_r_wb, req_addr, req_wdata, C_out_valid, C_data_r,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, gnt_id,
               C_in_valid, C_r_wb, C_addr, C_data_w
    );

    modport master (
        output req_valid, req_r_wb, req_addr, req_wdata, C_out_valid, C_data_r,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy, gnt_id,
               C_in_valid, C_r_wb, C_addr, C_data_w
    );
endinterface

// File: rtl/bridge_arbiter.sv
// Round-robin owner of the single DRAM bridge command port, one transaction outstanding; ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: req_valid at T -> req_ready/C_in_valid at T+1; rsp_valid one cycle after C_out_valid.
// Backpressure: losing requesters hold req_valid in place while busy; the bridge response is never stalled.
module bridge_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    bridge_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("bridge_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr, gnt_id, winner, cand;
    logic              any_req, grant, rsp_fire, rsp_timeout;
    logic [NREQ-1:0]   req_ready, req_ready_nxt, rsp_valid, rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_data, cmd_wdata;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_valid, cmd_r_wb, busy;

    // First active requester at or above rr_ptr, wrapping around.
    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!any_req && bus.req_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_err <= rsp_timeout;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign bus.rsp_err = rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Next-state logic; a bridge completion outranks a same-cycle timeout.
    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        rsp_fire    = 1'b0;
        rsp_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.C_out_valid) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    rsp_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_nxt = '0;
        rsp_valid_nxt = '0;
        if (grant)
            req_ready_nxt[winner] = 1'b1;
        if (rsp_fire || rsp_timeout)
            rsp_valid_nxt[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_r_wb  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            busy      <= (state_nxt != IDLE);
            cmd_valid <= (state_nxt == ISSUE);
            if (grant) begin
                gnt_id    <= winner;
                rr_ptr    <= IDW'((int'(winner) + 1) % NREQ);
                cmd_r_wb  <= bus.req_r_wb[winner];
                cmd_addr  <= bus.req_addr[winner*ADDR_W +: ADDR_W];
                cmd_wdata <= bus.req_wdata[winner*DATA_W +: DATA_W];
            end
            if (rsp_fire)
                rsp_data <= bus.C_data_r;
            else if (rsp_timeout)
                rsp_data <= '0;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.busy       = busy;
    assign bus.gnt_id     = gnt_id;
    assign bus.C_in_valid = cmd_valid;
    assign bus.C_r_wb     = cmd_r_wb;
    assign bus.C_addr     = cmd_addr;
    assign bus.C_data_w   = cmd_wdata;
endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter: reset, read, write, fairness, stray/reset, back-to-back, optional timeout.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_bridge_arbiter;
    localparam int NREQ = 4, ADDR_W = 8, DATA_W = 64;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1023;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bridge_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    bridge_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_valid   = '0;
        bus.req_r_wb    = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.C_out_valid = 1'b0;
        bus.C_data_r    = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic r_wb, input logic [7:0] a, input logic [63:0] d);
        bus.req_valid[i]           = 1'b1;
        bus.req_r_wb[i]            = r_wb;
        bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // Returns in the ISSUE cycle (req_ready visible) or with ok = 0 after a bounded wait.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic respond(input logic [63:0] d);
        bus.C_out_valid = 1'b1;
        bus.C_data_r    = d;
        tick();
        bus.C_out_valid = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        bus.req_valid = 4'hF;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.C_in_valid, bus.rsp_err} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got rdy=%b rsp=%b busy=%b civ=%b err=%b exp all 0",
                     bus.req_ready, bus.rsp_valid, bus.busy, bus.C_in_valid, bus.rsp_err);
        end
        n_cmp++;
        if ({bus.gnt_id, bus.C_addr, bus.C_r_wb} !== 11'b0 || bus.rsp_data !== 64'h0 || bus.C_data_w !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_data got gnt=%0d addr=%h rwb=%b rdata=%h wdata=%h exp all 0",
                     bus.gnt_id, bus.C_addr, bus.C_r_wb, bus.rsp_data, bus.C_data_w);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read;
        set_req(0, 1'b1, 8'h12, 64'h0);
        tick();
        n_cmp++;
        if (bus.req_ready !== 4'b0001 || bus.C_in_valid !== 1'b1 || bus.C_addr !== 8'h12 ||
            bus.C_r_wb !== 1'b1 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_issue got rdy=%b civ=%b addr=%h rwb=%b busy=%b exp 0001 1 12 1 1",
                     bus.req_ready, bus.C_in_valid, bus.C_addr, bus.C_r_wb, bus.busy);
        end
        bus.req_valid[0] = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (bus.C_in_valid !== 1'b0 || bus.rsp_valid !== 4'b0 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0) begin
            n_bad++;
            $display("FAIL rd_wait got civ=%b rsp=%b busy=%b rdy=%b exp 0 0000 1 0000",
                     bus.C_in_valid, bus.rsp_valid, bus.busy, bus.req_ready);
        end
        respond(64'hDEAD_BEEF_0123_4567);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 64'hDEAD_BEEF_0123_4567 ||
            bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_rsp got rsp=%b data=%h err=%b busy=%b exp 0001 deadbeef01234567 0 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== 64'hDEAD_BEEF_0123_4567) begin
            n_bad++;
            $display("FAIL rd_hold got rsp=%b data=%h exp 0000 deadbeef01234567", bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_write;
        bit ok;
        bit stable_ok;
        set_req(2, 1'b0, 8'hFF, 64'h1);
        wait_grant(ok);
        n_cmp++;
        if (!ok || bus.req_ready !== 4'b0100 || bus.gnt_id !== 2'd2 || bus.C_data_w !== 64'h1 ||
            bus.C_r_wb !== 1'b0 || bus.C_addr !== 8'hFF) begin
            n_bad++;
            $display("FAIL wr_issue got ok=%b rdy=%b gnt=%0d wdata=%h rwb=%b addr=%h exp 1 0100 2 1 0 ff",
                     ok, bus.req_ready, bus.gnt_id, bus.C_data_w, bus.C_r_wb, bus.C_addr);
        end
        bus.req_valid[2] = 1'b0;
        stable_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.C_in_valid !== 1'b0 || bus.C_data_w !== 64'h1 || bus.C_r_wb !== 1'b0 ||
                bus.C_addr !== 8'hFF || bus.rsp_valid !== 4'b0)
                stable_ok = 1'b0;
        end
        n_cmp++;
        if (!stable_ok) begin
            n_bad++;
            $display("FAIL wr_stable got civ=%b wdata=%h rwb=%b addr=%h exp 0 1 0 ff held",
                     bus.C_in_valid, bus.C_data_w, bus.C_r_wb, bus.C_addr);
        end
        respond(64'hAAAA_5555);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 64'hAAAA_5555 || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rsp got rsp=%b data=%h err=%b exp 0100 aaaa5555 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
    endtask

    task automatic test_stray_and_reset;
        bit ok;
        bus.C_out_valid = 1'b1;
        bus.C_data_r    = 64'h77;
        tick();
        bus.C_out_valid = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0 || bus.rsp_data !== 64'hAAAA_5555) begin
            n_bad++;
            $display("FAIL stray_idle got rsp=%b busy=%b data=%h exp 0000 0 aaaa5555",
                     bus.rsp_valid, bus.busy, bus.rsp_data);
        end
        // rr_ptr is 3 here, so requester 1 wins after wrapping past 3 and 0.
        set_req(1, 1'b1, 8'h33, 64'h0);
        wait_grant(ok);
        n_cmp++;
        if (!ok || bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL wrap_grant got ok=%b rdy=%b exp 1 0010", ok, bus.req_ready);
        end
        bus.req_valid[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.gnt_id !== 2'd0 || bus.C_addr !== 8'h00) begin
            n_bad++;
            $display("FAIL midwait_rst got busy=%b gnt=%0d addr=%h exp 0 0 00", bus.busy, bus.gnt_id, bus.C_addr);
        end
        rst = 1'b0;
        respond(64'h99);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== 64'h0) begin
            n_bad++;
            $display("FAIL stray_after_rst got rsp=%b data=%h exp 0000 0", bus.rsp_valid, bus.rsp_data);
        end
        set_req(0, 1'b1, 8'h40, 64'h0);
        set_req(3, 1'b1, 8'h43, 64'h0);
        wait_grant(ok);
        n_cmp++;
        if (!ok || bus.req_ready !== 4'b0001 || bus.C_addr !== 8'h40) begin
            n_bad++;
            $display("FAIL rst_ptr got ok=%b rdy=%b addr=%h exp 1 0001 40", ok, bus.req_ready, bus.C_addr);
        end
        clear_inputs();
        tick();
        respond(64'h4040);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 64'h4040) begin
            n_bad++;
            $display("FAIL rst_ptr_rsp got rsp=%b data=%h exp 0001 4040", bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_fairness;
        bit ok;
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, 8'(i * 16), 64'h0);
        for (int g = 0; g < 5; g++) begin
            exp = 4'b0001 << (g % 4);
            wait_grant(ok);
            n_cmp++;
            if (!ok || bus.req_ready !== exp || bus.gnt_id !== 2'(g % 4) || bus.C_addr !== 8'((g % 4) * 16)) begin
                n_bad++;
                $display("FAIL fair_grant%0d got ok=%b rdy=%b gnt=%0d addr=%h exp 1 %b %0d %h",
                         g, ok, bus.req_ready, bus.gnt_id, bus.C_addr, exp, g % 4, (g % 4) * 16);
            end
            tick();
            respond(64'h100 + 64'(g));
            n_cmp++;
            if (bus.rsp_valid !== exp || bus.rsp_data !== 64'h100 + 64'(g)) begin
                n_bad++;
                $display("FAIL fair_rsp%0d got rsp=%b data=%h exp %b %h",
                         g, bus.rsp_valid, bus.rsp_data, exp, 64'h100 + 64'(g));
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back;
        bit ok;
        do_reset();
        set_req(1, 1'b1, 8'h51, 64'h0);
        wait_grant(ok);
        n_cmp++;
        if (!ok || bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL b2b_first got ok=%b rdy=%b exp 1 0010", ok, bus.req_ready);
        end
        bus.req_valid[1] = 1'b0;
        set_req(3, 1'b0, 8'h53, 64'h3);
        tick();
        respond(64'hB1);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0010 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_rsp1 got rsp=%b busy=%b exp 0010 0", bus.rsp_valid, bus.busy);
        end
        bus.req_valid[1] = 1'b1;
        tick();
        n_cmp++;
        if (bus.req_ready !== 4'b1000 || bus.C_addr !== 8'h53 || bus.C_r_wb !== 1'b0 || bus.C_data_w !== 64'h3) begin
            n_bad++;
            $display("FAIL b2b_grant3 got rdy=%b addr=%h rwb=%b wdata=%h exp 1000 53 0 3",
                     bus.req_ready, bus.C_addr, bus.C_r_wb, bus.C_data_w);
        end
        bus.req_valid[3] = 1'b0;
        tick();
        respond(64'hB3);
        n_cmp++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 64'hB3) begin
            n_bad++;
            $display("FAIL b2b_rsp3 got rsp=%b data=%h exp 1000 b3", bus.rsp_valid, bus.rsp_data);
        end
        tick();
        n_cmp++;
        if (bus.req_ready !== 4'b0010 || bus.C_addr !== 8'h51) begin
            n_bad++;
            $display("FAIL b2b_grant1 got rdy=%b addr=%h exp 0010 51", bus.req_ready, bus.C_addr);
        end
        bus.req_valid[1] = 1'b0;
        tick();
        respond(64'hB5);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 64'hB5) begin
            n_bad++;
            $display("FAIL b2b_rsp1b got rsp=%b data=%h exp 0010 b5", bus.rsp_valid, bus.rsp_data);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        bit quiet;
        set_req(2, 1'b1, 8'h22, 64'h0);
        wait_grant(ok);
        n_cmp++;
        if (!ok || bus.req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL to_grant got ok=%b rdy=%b exp 1 0100", ok, bus.req_ready);
        end
        bus.req_valid[2] = 1'b0;
        tick();
        quiet = 1'b1;
        repeat (TO - 1) begin
            tick();
            if (bus.rsp_valid !== 4'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL to_early got rsp=%b before %0d wait cycles exp 0000", bus.rsp_valid, TO);
        end
        tick();
        n_cmp++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 64'h0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL to_rsp got rsp=%b err=%b data=%h busy=%b exp 0100 1 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.busy);
        end
        respond(64'h5A);
        n_cmp++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 64'h0) begin
            n_bad++;
            $display("FAIL to_stray got rsp=%b err=%b data=%h exp 0000 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write();
        test_stray_and_reset();
        test_fairness();
        test_back_to_back();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion exp summary before 500us");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
- Shares the single DRAM bridge command port among NREQ requester controllers (e.g. FD core, refill engine, debug loader).
- Round-robin arbitration with exactly one transaction outstanding at a time.
- Latches the winner's command, drives the bridge C_* handshake, and routes the bridge response back to the owning requester.
- Sits between requester-side controllers and the bridge; it performs no address or byte-order translation.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ), derived.
- ADDR_W, 8, bridge word address width.
- DATA_W, 64, bridge data width.
- TIMEOUT, 1023, WAIT-cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request, level; held until req_ready.
- req_r_wb  in  NREQ  1 = read, 0 = write.
- req_addr  in  NREQ*ADDR_W  slice i = [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  slice i = [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot, 1-cycle grant/accept pulse.
- rsp_valid  out  NREQ  one-hot, 1-cycle completion pulse.
- rsp_data  out  DATA_W  read data; for writes, the value returned by the bridge.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- busy  out  1  high while state != IDLE.
- gnt_id  out  IDW  current or last owner.
- C_in_valid  out  1  bridge command pulse.
- C_r_wb  out  1  bridge read/write select.
- C_addr  out  ADDR_W  bridge address.
- C_data_w  out  DATA_W  bridge write data.
- C_out_valid  in  1  bridge completion pulse.
- C_data_r  in  DATA_W  bridge read data.

Behaviour:
- Reset: the already-decided interface is one clock (clk) with a synchronous, active-high reset (rst). On rst:
  - All outputs = 0, state = IDLE, rr_ptr = 0, gnt_id = 0.
  - Any in-flight transaction is dropped. A later stray C_out_valid is ignored.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid: the winner is the first set bit searching from rr_ptr upward, wrapping at NREQ-1 -> 0.
  - Latch the winner's r_wb, addr and wdata into C_r_wb, C_addr and C_data_w.
  - gnt_id <= winner; rr_ptr <= (winner+1) mod NREQ; next state ISSUE.
  - No request: stay in IDLE; rr_ptr unchanged.
- ISSUE (one cycle): C_in_valid = 1 and req_ready[gnt_id] = 1 in this cycle only; next state WAIT.
  - The requester must drop req_valid the cycle after req_ready.
- WAIT:
  - C_in_valid = 0. C_r_wb, C_addr and C_data_w hold stable until the next grant.
  - On C_out_valid: rsp_data <= C_data_r, rsp_valid[gnt_id] pulses for 1 cycle in the next cycle, state returns to IDLE.
- In the cycle rsp_valid is high the arbiter is already in IDLE and may grant again, giving back-to-back service.
- Minimum latency: req_valid sampled at T -> req_ready and C_in_valid at T+1 -> rsp_valid one cycle after C_out_valid.
- C_out_valid in IDLE or ISSUE is ignored; no response is produced.
- Requests that arrive while busy wait in place. A requester dropping req_valid before grant is legal and loses its turn.
- Simultaneous requests: a single grant only. rr_ptr guarantees every active requester is served within NREQ grants.
- rsp_data holds its last value between responses. rsp_err = 0 except as defined under the optional feature.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entering WAIT.
  - If it reaches TIMEOUT with no C_out_valid, the arbiter pulses rsp_valid[gnt_id] with rsp_err = 1 and rsp_data = 0, then returns to IDLE.
  - C_out_valid arriving in the same cycle as the timeout wins: normal response, rsp_err = 0.
  - A later stray C_out_valid is ignored.
- Undefined: no counter; WAIT lasts indefinitely; rsp_err is tied to 0.

Test Plan:
- Single read: req0 read, addr 8'h12; bridge returns C_data_r = 64'hDEAD_BEEF_0123_4567 after 5 cycles -> req_ready[0] at T+1, C_addr = 8'h12, C_r_wb = 1, rsp_valid[0] with that data, rsp_err = 0.
- Fairness: all four requesters held valid from reset -> grant order 0, 1, 2, 3, 0; each gets exactly one rsp_valid per round.
- Write with response: req2 write, addr 8'hFF, wdata 64'h1 -> C_data_w = 64'h1 and C_r_wb = 0 stable through WAIT; only rsp_valid[2] pulses.
- Stray and reset: C_out_valid pulsed in IDLE -> no rsp_valid. rst asserted mid-WAIT -> busy = 0 next cycle; the subsequent C_out_valid is ignored; the next grant starts from requester 0.
- Back-to-back: req1 re-asserts in the cycle rsp_valid[1] is high while req3 is pending -> req3 is granted next (rr_ptr = 2), then req1.
- ARB_TIMEOUT_EN with TIMEOUT = 16: bridge never responds -> rsp_valid[gnt] with rsp_err = 1 and rsp_data = 0, 16 cycles after entering WAIT; a later C_out_valid is ignored.
